// File: rtl/lbm_bc_addr_gen_if.sv
// lbm_bc_addr_gen_if
// Element stream from the LBM cell address generator to its consumer
// (boundary-condition or collision engine).
//
// Signals:
//   Valid    producer -> consumer   element fields are meaningful
//   Ready    consumer -> producer   consumer accepts the current element
//   Address  producer -> consumer   linear cell address, Y*GRID_W+X
//   X, Y     producer -> consumer   cell coordinates (row 0 = north)
//   Side     producer -> consumer   {N,S,W,E} wall tag of the cell
//   Last     producer -> consumer   final element of the sweep
//
// Modports: master (generator side), slave (consumer side).
interface lbm_bc_addr_gen_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int X_WIDTH       = 4,
    parameter int Y_WIDTH       = 4
);
    logic                     Valid;
    logic                     Ready;
    logic [ADDRESS_WIDTH-1:0] Address;
    logic [X_WIDTH-1:0]       X;
    logic [Y_WIDTH-1:0]       Y;
    logic [3:0]               Side;
    logic                     Last;

    modport master (
        output Valid, Address, X, Y, Side, Last,
        input  Ready
    );

    modport slave (
        input  Valid, Address, X, Y, Side, Last,
        output Ready
    );
endinterface

// File: rtl/lbm_bc_addr_gen.sv
// lbm_bc_addr_gen
// Boundary/interior cell address generator for a GRID_W x GRID_H LBM lattice.
// A Start pulse in IDLE latches Mode and walks the selected cell class in
// raster order (Y outer, X inner), emitting one element per accepted
// Valid/Ready handshake on the stream interface.
//
// Ports:
//   Clk      clock, rising edge
//   Reset    synchronous, active-high; abandons any sweep in progress
//   Start    begin a sweep (only honoured in IDLE)
//   Mode     0 perimeter, 1 top+bottom rows, 2 left+right columns, 3 interior
//   Busy     high while the sweep is running
//   Done     one-cycle pulse after the final element is accepted
//   stream   master side of lbm_bc_addr_gen_if (Valid/Ready/Address/X/Y/Side/Last)
module lbm_bc_addr_gen #(
    parameter int GRID_W        = 16,
    parameter int GRID_H        = 16,
    parameter int ADDRESS_WIDTH = $clog2(GRID_W*GRID_H),
    parameter int X_WIDTH       = $clog2(GRID_W),
    parameter int Y_WIDTH       = $clog2(GRID_H)
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic [1:0]               Mode,
    output logic                     Busy,
    output logic                     Done,
    lbm_bc_addr_gen_if.master        stream
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_PERIM     = 2'd0,
        MODE_TOPBOT    = 2'd1,
        MODE_LEFTRIGHT = 2'd2,
        MODE_INTERIOR  = 2'd3
    } mode_t;

    localparam logic [X_WIDTH-1:0]       X_ONE        = X_WIDTH'(1);
    localparam logic [Y_WIDTH-1:0]       Y_ONE        = Y_WIDTH'(1);
    localparam logic [X_WIDTH-1:0]       X_LAST       = X_WIDTH'(GRID_W - 1);
    localparam logic [X_WIDTH-1:0]       X_INNER_LAST = X_WIDTH'(GRID_W - 2);
    localparam logic [Y_WIDTH-1:0]       Y_LAST       = Y_WIDTH'(GRID_H - 1);
    localparam logic [Y_WIDTH-1:0]       Y_INNER_LAST = Y_WIDTH'(GRID_H - 2);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE     = ADDRESS_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ACROSS  = ADDRESS_WIDTH'(GRID_W - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_INNER_WRAP = ADDRESS_WIDTH'(3);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_LAST_ROW   = ADDRESS_WIDTH'((GRID_H - 1) * GRID_W);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_FIRST_INNER = ADDRESS_WIDTH'(GRID_W + 1);

    state_t                     state;
    state_t                     stateNext;
    mode_t                      modeReg;
    logic                       validReg;
    logic [X_WIDTH-1:0]         xReg;
    logic [Y_WIDTH-1:0]         yReg;
    logic [ADDRESS_WIDTH-1:0]   addrReg;

    logic [X_WIDTH-1:0]         nextX;
    logic [Y_WIDTH-1:0]         nextY;
    logic [ADDRESS_WIDTH-1:0]   nextAddr;
    logic                       isLast;
    logic                       fullRow;
    logic                       accept;

    assign accept = validReg && stream.Ready;

    // Successor of the current cell within the latched class. The address
    // steps incrementally: +1 along a row or into the next row, +(W-1) to hop
    // from the west wall to the east wall, +3 to wrap between interior rows,
    // and a constant jump from the end of row 0 to the start of row H-1.
    always_comb begin
        nextX    = xReg + X_ONE;
        nextY    = yReg;
        nextAddr = addrReg + ADDR_ONE;
        fullRow  = (yReg == '0) || (yReg == Y_LAST);
        isLast   = 1'b0;
        case (modeReg)
            MODE_INTERIOR: begin
                isLast = (xReg == X_INNER_LAST) && (yReg == Y_INNER_LAST);
                if (xReg == X_INNER_LAST) begin
                    nextX    = X_ONE;
                    nextY    = yReg + Y_ONE;
                    nextAddr = addrReg + ADDR_INNER_WRAP;
                end
            end
            default: begin
                isLast = (xReg == X_LAST) && (yReg == Y_LAST);
                if (xReg == X_LAST) begin
                    nextX = '0;
                    nextY = yReg + Y_ONE;
                    if (modeReg == MODE_TOPBOT) begin
                        nextY    = Y_LAST;
                        nextAddr = ADDR_LAST_ROW;
                    end
                end else if ((modeReg == MODE_LEFTRIGHT) ||
                             ((modeReg == MODE_PERIM) && !fullRow)) begin
                    // Only X=0 reaches here in these rows; jump to the east wall.
                    nextX    = X_LAST;
                    nextAddr = addrReg + ADDR_ACROSS;
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (Start) stateNext = RUN;
            RUN:     if (accept && isLast) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // The first cell is loaded when Start is taken; Valid rises one cycle
    // later, then stays high until the final element is accepted.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            modeReg  <= MODE_PERIM;
            validReg <= 1'b0;
            xReg     <= '0;
            yReg     <= '0;
            addrReg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    validReg <= 1'b0;
                    if (Start) begin
                        modeReg <= mode_t'(Mode);
                        if (mode_t'(Mode) == MODE_INTERIOR) begin
                            xReg    <= X_ONE;
                            yReg    <= Y_ONE;
                            addrReg <= ADDR_FIRST_INNER;
                        end else begin
                            xReg    <= '0;
                            yReg    <= '0;
                            addrReg <= '0;
                        end
                    end
                end
                RUN: begin
                    if (!validReg) begin
                        validReg <= 1'b1;
                    end else if (stream.Ready) begin
                        if (isLast) begin
                            validReg <= 1'b0;
                        end else begin
                            xReg    <= nextX;
                            yReg    <= nextY;
                            addrReg <= nextAddr;
                        end
                    end
                end
                default: validReg <= 1'b0;
            endcase
        end
    end

    assign stream.Valid   = validReg;
    assign stream.Address = addrReg;
    assign stream.X       = xReg;
    assign stream.Y       = yReg;
    assign stream.Last    = validReg && isLast;
    // Side is gated by Valid so the idle/reset value is all zeros.
    assign stream.Side    = validReg ? {yReg == '0, yReg == Y_LAST, xReg == '0, xReg == X_LAST}
                                     : 4'b0000;
    assign Busy = (state == RUN);
    assign Done = (state == DONE);

endmodule

// File: tb/tb_lbm_bc_addr_gen.sv
// tb_lbm_bc_addr_gen
// Scoreboard bench for lbm_bc_addr_gen: a 16x16 instance and a 5x4 instance.
// Stimulus pushes expected elements into per-instance queues; monitors pop
// and compare on every handshake observed at the falling edge.
module tb_lbm_bc_addr_gen;

    typedef struct {
        int addr;
        int x;
        int y;
        int side;
        int last;
    } elem_t;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       start16 = 1'b0;
    logic       start5 = 1'b0;
    logic [1:0] mode16 = 2'd0;
    logic [1:0] mode5 = 2'd0;
    logic       busy16, done16, busy5, done5;

    int    checkCount = 0;
    int    passCount = 0;
    elem_t exp16[$];
    elem_t exp5[$];
    elem_t sweepBuf[$];
    elem_t got16;
    elem_t got5;
    int    hs16 = 0;
    int    hs5 = 0;
    bit    expectDone16 = 1'b0;
    bit    expectDone5 = 1'b0;
    bit    stalled16 = 1'b0;
    logic [7:0] heldAddr;
    logic [3:0] heldX, heldY, heldSide;
    logic       heldLast;
    int    lastY5 = 0;

    always #5 Clk = ~Clk;

    lbm_bc_addr_gen_if #(.ADDRESS_WIDTH(8), .X_WIDTH(4), .Y_WIDTH(4)) bus16 ();
    lbm_bc_addr_gen_if #(.ADDRESS_WIDTH(5), .X_WIDTH(3), .Y_WIDTH(2)) bus5 ();

    lbm_bc_addr_gen #(.GRID_W(16), .GRID_H(16)) dut16 (
        .Clk(Clk), .Reset(Reset), .Start(start16), .Mode(mode16),
        .Busy(busy16), .Done(done16), .stream(bus16)
    );

    lbm_bc_addr_gen #(.GRID_W(5), .GRID_H(4)) dut5 (
        .Clk(Clk), .Reset(Reset), .Start(start5), .Mode(mode5),
        .Busy(busy5), .Done(done5), .stream(bus5)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Reference sweep: scan every cell in raster order and keep those in the class.
    task automatic buildSweep(input int w, input int h, input int mode);
        elem_t e;
        bit take;
        sweepBuf.delete();
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                case (mode)
                    0:       take = (x == 0) || (x == w-1) || (y == 0) || (y == h-1);
                    1:       take = (y == 0) || (y == h-1);
                    2:       take = (x == 0) || (x == w-1);
                    default: take = (x > 0) && (x < w-1) && (y > 0) && (y < h-1);
                endcase
                if (take) begin
                    e.addr = y*w + x;
                    e.x = x;
                    e.y = y;
                    e.side = 8*int'(y == 0) + 4*int'(y == h-1) + 2*int'(x == 0) + int'(x == w-1);
                    e.last = 0;
                    sweepBuf.push_back(e);
                end
            end
        end
        e = sweepBuf.pop_back();
        e.last = 1;
        sweepBuf.push_back(e);
    endtask

    task automatic checkZero16(input string name);
        checkOutput(name, int'({bus16.Valid, bus16.Last, busy16, done16,
                                bus16.Address, bus16.X, bus16.Y, bus16.Side}), 0);
    endtask

    // Issue a Start for the 16x16 instance and check first-element latency.
    task automatic applyStimulus16(input int mode);
        int firstAddr;
        buildSweep(16, 16, mode);
        firstAddr = sweepBuf[0].addr;
        foreach (sweepBuf[i]) exp16.push_back(sweepBuf[i]);
        mode16 = 2'(mode);
        start16 = 1'b1;
        @(posedge Clk); #1;
        start16 = 1'b0;
        checkOutput("latency16_busy", int'(busy16), 1);
        checkOutput("latency16_valid_early", int'(bus16.Valid), 0);
        @(posedge Clk); #1;
        checkOutput("latency16_valid", int'(bus16.Valid), 1);
        checkOutput("latency16_first_addr", int'(bus16.Address), firstAddr);
    endtask

    task automatic waitSweep16(input int base, input int expectedCount,
                               input bit randomReady, input bit disturb, input int mode);
        int cycles;
        cycles = 0;
        while ((busy16 || done16 || exp16.size() != 0) && cycles < 3000) begin
            if (randomReady) bus16.Ready = 1'($urandom_range(0, 1));
            if (disturb && cycles == 3) mode16 = 2'((mode + 1) % 4);
            if (disturb && cycles == 6) start16 = 1'b1;
            if (disturb && cycles == 7) start16 = 1'b0;
            @(posedge Clk); #1;
            cycles++;
        end
        start16 = 1'b0;
        bus16.Ready = 1'b1;
        checkOutput("sweep16_timeout", int'(cycles >= 3000), 0);
        checkOutput("sweep16_count", hs16 - base, expectedCount);
        checkOutput("sweep16_leftover", exp16.size(), 0);
        @(posedge Clk); #1;
    endtask

    // Monitor for the 16x16 instance: Done pulse, stall stability, scoreboard.
    initial begin
        forever begin
            @(negedge Clk);
            checkOutput("done16_pulse", int'(done16), int'(expectDone16));
            expectDone16 = 1'b0;
            if (stalled16) begin
                checkOutput("stall16_valid", int'(bus16.Valid), 1);
                checkOutput("stall16_addr", int'(bus16.Address), int'(heldAddr));
                checkOutput("stall16_x", int'(bus16.X), int'(heldX));
                checkOutput("stall16_y", int'(bus16.Y), int'(heldY));
                checkOutput("stall16_side", int'(bus16.Side), int'(heldSide));
                checkOutput("stall16_last", int'(bus16.Last), int'(heldLast));
            end
            stalled16 = bus16.Valid && !bus16.Ready && !Reset;
            heldAddr = bus16.Address;
            heldX = bus16.X;
            heldY = bus16.Y;
            heldSide = bus16.Side;
            heldLast = bus16.Last;
            if (bus16.Valid && bus16.Ready && !Reset) begin
                if (exp16.size() == 0) begin
                    checkOutput("unexpected16_addr", int'(bus16.Address), -1);
                end else begin
                    got16 = exp16.pop_front();
                    checkOutput("elem16_addr", int'(bus16.Address), got16.addr);
                    checkOutput("elem16_x", int'(bus16.X), got16.x);
                    checkOutput("elem16_y", int'(bus16.Y), got16.y);
                    checkOutput("elem16_side", int'(bus16.Side), got16.side);
                    checkOutput("elem16_last", int'(bus16.Last), got16.last);
                end
                hs16++;
                if (bus16.Last) expectDone16 = 1'b1;
            end
        end
    end

    // Monitor for the 5x4 instance, including the address formula and row order.
    initial begin
        forever begin
            @(negedge Clk);
            checkOutput("done5_pulse", int'(done5), int'(expectDone5));
            expectDone5 = 1'b0;
            if (bus5.Valid && bus5.Ready && !Reset) begin
                checkOutput("addr5_formula", int'(bus5.Address), int'(bus5.Y)*5 + int'(bus5.X));
                checkOutput("y5_order", int'(int'(bus5.Y) >= lastY5), 1);
                lastY5 = int'(bus5.Y);
                if (exp5.size() == 0) begin
                    checkOutput("unexpected5_addr", int'(bus5.Address), -1);
                end else begin
                    got5 = exp5.pop_front();
                    checkOutput("elem5_addr", int'(bus5.Address), got5.addr);
                    checkOutput("elem5_x", int'(bus5.X), got5.x);
                    checkOutput("elem5_y", int'(bus5.Y), got5.y);
                    checkOutput("elem5_side", int'(bus5.Side), got5.side);
                    checkOutput("elem5_last", int'(bus5.Last), got5.last);
                end
                hs5++;
                if (bus5.Last) expectDone5 = 1'b1;
            end
        end
    end

    initial begin
        int base;
        int cycles;
        int addr5[8] = '{0, 4, 5, 9, 10, 14, 15, 19};
        int x5[8]    = '{0, 4, 0, 4, 0, 4, 0, 4};
        int y5[8]    = '{0, 0, 1, 1, 2, 2, 3, 3};
        int side5[8] = '{10, 9, 2, 1, 2, 1, 6, 5};
        elem_t e;

        bus16.Ready = 1'b1;
        bus5.Ready = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        checkZero16("reset16_outputs");
        checkOutput("reset5_outputs", int'({bus5.Valid, bus5.Last, busy5, done5,
                                            bus5.Address, bus5.X, bus5.Y, bus5.Side}), 0);
        Reset = 1'b0;
        @(posedge Clk); #1;

        // Perimeter, top/bottom rows, then interior with random stalls and disturbance.
        base = hs16;
        applyStimulus16(0);
        waitSweep16(base, 60, 1'b0, 1'b0, 0);
        base = hs16;
        applyStimulus16(1);
        waitSweep16(base, 32, 1'b0, 1'b0, 1);
        base = hs16;
        applyStimulus16(3);
        waitSweep16(base, 196, 1'b1, 1'b1, 3);

        // 5x4 left/right columns from a hand-written table.
        for (int i = 0; i < 8; i++) begin
            e.addr = addr5[i];
            e.x = x5[i];
            e.y = y5[i];
            e.side = side5[i];
            e.last = int'(i == 7);
            exp5.push_back(e);
        end
        lastY5 = 0;
        base = hs5;
        mode5 = 2'd2;
        start5 = 1'b1;
        @(posedge Clk); #1;
        start5 = 1'b0;
        cycles = 0;
        while ((busy5 || done5 || exp5.size() != 0) && cycles < 200) begin
            @(posedge Clk); #1;
            cycles++;
        end
        checkOutput("sweep5_timeout", int'(cycles >= 200), 0);
        checkOutput("sweep5_count", hs5 - base, 8);
        checkOutput("sweep5_leftover", exp5.size(), 0);
        @(posedge Clk); #1;

        // Reset after 20 perimeter elements, then a clean restart with a stray Start.
        base = hs16;
        applyStimulus16(0);
        cycles = 0;
        while ((hs16 - base) < 20 && cycles < 200) begin
            @(posedge Clk); #1;
            cycles++;
        end
        bus16.Ready = 1'b0;
        Reset = 1'b1;
        checkOutput("midreset16_elements", hs16 - base, 20);
        @(posedge Clk); #1;
        Reset = 1'b0;
        exp16.delete();
        checkZero16("midreset16_outputs");
        bus16.Ready = 1'b1;
        @(posedge Clk); #1;
        base = hs16;
        applyStimulus16(0);
        waitSweep16(base, 60, 1'b0, 1'b1, 0);

        // Start coinciding with Reset must leave the generator idle.
        Reset = 1'b1;
        start16 = 1'b1;
        mode16 = 2'd0;
        @(posedge Clk); #1;
        Reset = 1'b0;
        start16 = 1'b0;
        checkOutput("start_reset_busy", int'(busy16), 0);
        checkOutput("start_reset_valid", int'(bus16.Valid), 0);
        @(posedge Clk); #1;
        checkOutput("start_reset_still_idle", int'(busy16), 0);
        repeat (2) @(posedge Clk);
        #1;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
